// File: rtl/pwm_pkg.sv
// Shared types and constants for the shadow-registered PWM generator.
//   CNT_W       counter / compare width
//   CFG_RESET   active/pending configuration after reset
//   pwm_cfg_t   {period, duty, phase}, used for both the pending and active sets
//   dt_width()  width of the dead-time counter for a given dead time
package pwm_pkg;

  localparam int unsigned CNT_W = 26;

  localparam logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(998);
  localparam logic [CNT_W-1:0] DEFAULT_DUTY   = '0;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] duty;
    logic [CNT_W-1:0] phase;
  } pwm_cfg_t;

  localparam pwm_cfg_t CFG_RESET = '{
    period: DEFAULT_PERIOD,
    duty:   DEFAULT_DUTY,
    phase:  '0
  };

  // clog2(dt+1), but never narrower than one bit so DT = 0 still elaborates.
  function automatic int unsigned dt_width(input int unsigned dt);
    return ($clog2(dt + 1) < 1) ? 1 : $clog2(dt + 1);
  endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Complementary gate-drive stage with dead time.
// Registers the raw PWM level and holds both outputs off for DT cycles after every
// raw transition, so the two sides never conduct together.
//   clk, rst_n  PWM clock, asynchronous active-low reset
//   raw         unregistered PWM level from the comparator
//   en          run enable; 0 forces both outputs low on the next edge
//   pwm_h       high-side drive
//   pwm_l       low-side drive
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int unsigned DT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic en,
  output logic pwm_h,
  output logic pwm_l
);

  localparam int unsigned DW = dt_width(DT);
  localparam logic [DW-1:0] DT_SAT = DW'(DT);

  logic          raw_q;
  logic          en_q;
  logic [DW-1:0] dt_cnt_q;
  logic          dt_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q    <= 1'b0;
      en_q     <= 1'b0;
      dt_cnt_q <= DT_SAT;
    end else if (!en) begin
      // Park the counter saturated so re-enabling does not inherit a stale dead time.
      raw_q    <= 1'b0;
      en_q     <= 1'b0;
      dt_cnt_q <= DT_SAT;
    end else begin
      raw_q <= raw;
      en_q  <= 1'b1;
      if (raw != raw_q) begin
        dt_cnt_q <= '0;
      end else if (dt_cnt_q < DT_SAT) begin
        dt_cnt_q <= dt_cnt_q + 1'b1;
      end
    end
  end

  assign dt_ok = (dt_cnt_q >= DT_SAT);
  assign pwm_h = raw_q & dt_ok;
  assign pwm_l = ~raw_q & dt_ok & en_q;

endmodule

// File: rtl/pwm_shadow_dt.sv
// Shadow-registered, phase-shiftable PWM generator with complementary dead-time outputs.
// Period/duty/phase are captured into a pending set on load and promoted to the active
// set only in the wrap cycle, so the waveform never glitches mid-period.
//   clk, rst_n   PWM clock, asynchronous active-low reset
//   en           run enable; 0 holds the counter at 0 and forces outputs low
//   load         one-cycle strobe capturing period/duty/phase
//   period       terminal count (PWM period = period+1 cycles)
//   duty         high time in cycles (0 = always low, > period = always high)
//   phase        counter offset in cycles, clamped to period
//   pwm_h/pwm_l  complementary gate drives with dead time
//   cyc_start    pulse on the output cycle that corresponds to cnt == 0
//   pending      loaded values waiting for the next wrap
// CNT_W must equal pwm_pkg::CNT_W, which sizes the configuration struct.
module pwm_shadow_dt
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = pwm_pkg::CNT_W,
  parameter int unsigned DT    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  input  logic [CNT_W-1:0] phase,
  output logic             pwm_h,
  output logic             pwm_l,
  output logic             cyc_start,
  output logic             pending
);

  pwm_cfg_t         act_q;
  pwm_cfg_t         pend_q;
  pwm_cfg_t         in_cfg;
  logic             pending_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cyc_q;
  logic             at_top;
  logic [CNT_W-1:0] ph;
  logic [CNT_W:0]   sc;
  logic             raw;

  assign in_cfg = '{period: period, duty: duty, phase: phase};
  assign at_top = (cnt_q == act_q.period);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      act_q     <= CFG_RESET;
      pend_q    <= CFG_RESET;
      pending_q <= 1'b0;
      cyc_q     <= 1'b0;
    end else begin
      cyc_q <= en && (cnt_q == '0);
      if (!en) begin
        cnt_q <= '0;
        // Nothing is running, so a load can go straight to the active set.
        if (load) begin
          act_q     <= in_cfg;
          pending_q <= 1'b0;
        end
      end else begin
        cnt_q <= at_top ? '0 : cnt_q + 1'b1;
        if (at_top && pending_q) begin
          act_q <= pend_q;
        end
        // A load in the wrap cycle lands in pending and waits for the next wrap.
        if (load) begin
          pend_q    <= in_cfg;
          pending_q <= 1'b1;
        end else if (at_top) begin
          pending_q <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    ph = (act_q.phase < act_q.period) ? act_q.phase : act_q.period;
    if (cnt_q >= ph) begin
      sc = {1'b0, cnt_q - ph};
    end else begin
      // Wrap the shifted count back into [0, period].
      sc = {1'b0, cnt_q} + {1'b0, act_q.period} + (CNT_W + 1)'(1) - {1'b0, ph};
    end
    raw = en & (sc < {1'b0, act_q.duty});
  end

  pwm_deadtime #(
    .DT (DT)
  ) u_deadtime (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (raw),
    .en    (en),
    .pwm_h (pwm_h),
    .pwm_l (pwm_l)
  );

  assign cyc_start = cyc_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_pwm_shadow_dt.sv
// Self-checking bench for pwm_shadow_dt (DT = 4): directed scenarios plus randomized
// stimulus, every cycle compared against a behavioural model of the PWM rules.
module tb_pwm_shadow_dt;

  localparam int unsigned CW = 26;
  localparam int unsigned DT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          load;
  logic [CW-1:0] period;
  logic [CW-1:0] duty;
  logic [CW-1:0] phase;
  logic          pwm_h;
  logic          pwm_l;
  logic          cyc_start;
  logic          pending;

  pwm_shadow_dt #(
    .CNT_W (CW),
    .DT    (DT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .period    (period),
    .duty      (duty),
    .phase     (phase),
    .pwm_h     (pwm_h),
    .pwm_l     (pwm_l),
    .cyc_start (cyc_start),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural model: counter position, active/pending sets, and a short history of the
  // registered raw level (outputs are enabled once the last DT+1 levels agree).
  longint m_cnt;
  longint a_per, a_duty, a_ph;
  longint p_per, p_duty, p_ph;
  bit     m_pend, m_rawq, m_cyc, m_enq;
  bit     hist[$];

  // Per-period measurements taken between consecutive cyc_start pulses.
  int  since, h_acc, l_acc, cur_rise;
  int  last_h, last_l, last_gap, last_rise;
  bit  prev_h;

  task automatic model_reset();
    m_cnt  = 0;
    a_per  = 998; a_duty = 0; a_ph = 0;
    p_per  = 998; p_duty = 0; p_ph = 0;
    m_pend = 0; m_rawq = 0; m_cyc = 0; m_enq = 0;
    hist.delete();
    repeat (DT + 1) hist.push_back(1'b0);
  endtask

  task automatic model_edge();
    longint ph, sc;
    bit raw, wrap;
    raw = 0;
    if (en) begin
      ph  = (a_ph < a_per) ? a_ph : a_per;
      sc  = (m_cnt + a_per + 1 - ph) % (a_per + 1);
      raw = (sc < a_duty);
    end
    m_cyc  = en && (m_cnt == 0);
    m_enq  = en;
    m_rawq = raw;
    if (!en) begin
      hist.delete();
      repeat (DT + 1) hist.push_back(1'b0);
    end else begin
      hist.push_back(raw);
      void'(hist.pop_front());
    end
    if (!en) begin
      m_cnt = 0;
      if (load) begin
        a_per = period; a_duty = duty; a_ph = phase;
        m_pend = 0;
      end
    end else begin
      wrap  = (m_cnt == a_per);
      m_cnt = wrap ? 0 : m_cnt + 1;
      if (wrap && m_pend) begin
        a_per = p_per; a_duty = p_duty; a_ph = p_ph;
      end
      if (load) begin
        p_per = period; p_duty = duty; p_ph = phase;
        m_pend = 1;
      end else if (wrap) begin
        m_pend = 0;
      end
    end
  endtask

  task automatic step();
    bit stable;
    @(posedge clk);
    model_edge();
    #1;
    stable = 1;
    foreach (hist[i]) if (hist[i] != hist[0]) stable = 0;
    check_eq("pwm_h", pwm_h, m_rawq && stable);
    check_eq("pwm_l", pwm_l, !m_rawq && stable && m_enq);
    check_eq("cyc_start", cyc_start, m_cyc);
    check_eq("pending", pending, m_pend);
    check_eq("overlap", pwm_h & pwm_l, 0);
    if (cyc_start) begin
      last_h    = h_acc;
      last_l    = l_acc;
      last_gap  = since + 1;
      last_rise = cur_rise;
      h_acc = 0; l_acc = 0; since = 0; cur_rise = -1;
    end else begin
      since++;
    end
    h_acc += int'(pwm_h);
    l_acc += int'(pwm_l);
    if (pwm_h && !prev_h && cur_rise < 0) cur_rise = since;
    prev_h = pwm_h;
  endtask

  task automatic run_periods(input int n);
    int seen = 0;
    int budget = n * 1100 + 200;
    while (seen < n && budget > 0) begin
      step();
      if (cyc_start) seen++;
      budget--;
    end
    check_eq("period_timeout", seen, n);
  endtask

  task automatic wait_cnt(input longint v);
    int budget = 2500;
    while (m_cnt != v && budget > 0) begin
      step();
      budget--;
    end
    check_eq("cnt_timeout", m_cnt, v);
  endtask

  task automatic load_cfg(input int unsigned p, input int unsigned d, input int unsigned ph);
    period = CW'(p);
    duty   = CW'(d);
    phase  = CW'(ph);
    load   = 1'b1;
    step();
    load   = 1'b0;
  endtask

  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check_eq({tag, "_h"}, pwm_h, 0);
    check_eq({tag, "_l"}, pwm_l, 0);
    check_eq({tag, "_cyc"}, cyc_start, 0);
    check_eq({tag, "_pend"}, pending, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int unsigned p, d, ph, n;
    rst_n = 1'b0; en = 1'b0; load = 1'b0;
    period = '0; duty = '0; phase = '0;
    since = 0; h_acc = 0; l_acc = 0; cur_rise = -1; prev_h = 0;
    last_h = 0; last_l = 0; last_gap = 0; last_rise = -1;
    model_reset();
    #2;
    check_eq("reset_h", pwm_h, 0);
    check_eq("reset_l", pwm_l, 0);
    check_eq("reset_cyc", cyc_start, 0);
    check_eq("reset_pend", pending, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic duty: 499 of 999 minus 4 cycles of dead time on each side.
    en = 1'b1;
    load_cfg(998, 499, 0);
    check_eq("basic_pend", pending, 1);
    run_periods(3);
    check_eq("basic_h", last_h, 495);
    check_eq("basic_l", last_l, 496);
    check_eq("basic_gap", last_gap, 999);
    check_eq("basic_rise", last_rise, 4);

    // Mid-period updates: the later load wins, the running period is untouched.
    wait_cnt(300);
    load_cfg(998, 200, 0);
    check_eq("mid_pend", pending, 1);
    wait_cnt(400);
    load_cfg(998, 100, 0);
    run_periods(1);
    check_eq("mid_keep_h", last_h, 495);
    run_periods(1);
    check_eq("mid_new_h", last_h, 96);
    check_eq("mid_new_l", last_l, 895);

    // Duty boundaries.
    load_cfg(998, 0, 0);
    run_periods(3);
    check_eq("duty0_h", last_h, 0);
    check_eq("duty0_l", last_l, 999);
    load_cfg(998, 999, 0);
    run_periods(3);
    check_eq("duty999_h", last_h, 999);
    check_eq("duty999_l", last_l, 0);
    load_cfg(998, 5000, 0);
    run_periods(3);
    check_eq("duty5000_h", last_h, 999);
    check_eq("duty5000_gap", last_gap, 999);

    // Load in the wrap cycle: one more full-high period, then duty 499 (no rise at start).
    wait_cnt(998);
    load_cfg(998, 499, 0);
    check_eq("wrapload_pend", pending, 1);
    run_periods(2);
    check_eq("wrapload_old_h", last_h, 999);
    run_periods(1);
    check_eq("wrapload_new_h", last_h, 499);
    check_eq("wrapload_new_l", last_l, 496);

    // Phase shift: rising edge moves 250 cycles later; phase beyond period clamps to it.
    load_cfg(998, 499, 250);
    run_periods(3);
    check_eq("phase250_rise", last_rise, 254);
    check_eq("phase250_h", last_h, 495);
    load_cfg(998, 499, 2000);
    run_periods(3);
    check_eq("phase2000_rise", last_rise, 3);
    check_eq("phase2000_h", last_h, 495);

    // Pulse shorter than the dead time disappears.
    load_cfg(998, 3, 0);
    run_periods(3);
    check_eq("short_h", last_h, 0);
    check_eq("short_l", last_l, 992);

    // Reset at cnt 600 discards pending data and restores the default set.
    load_cfg(998, 499, 0);
    run_periods(3);
    wait_cnt(600);
    load_cfg(998, 700, 0);
    pulse_reset("midrst");
    run_periods(3);
    check_eq("postrst_h", last_h, 0);
    check_eq("postrst_l", last_l, 999);
    check_eq("postrst_gap", last_gap, 999);

    // Disable, load while disabled, re-enable with the new set in force at once.
    load_cfg(998, 499, 0);
    run_periods(2);
    en = 1'b0;
    step();
    check_eq("dis_h", pwm_h, 0);
    check_eq("dis_l", pwm_l, 0);
    repeat (8) step();
    load_cfg(98, 49, 0);
    check_eq("dis_pend", pending, 0);
    step();
    en = 1'b1;
    run_periods(2);
    check_eq("reen_gap", last_gap, 99);
    check_eq("reen_h", last_h, 45);
    check_eq("reen_l", last_l, 46);

    // Randomized: short periods, random enables, loads, resets and out-of-range values.
    en = 1'b0;
    load_cfg(10, 5, 0);
    for (int it = 0; it < 300; it++) begin
      p = $urandom_range(0, 40);
      case ($urandom_range(0, 3))
        0:       d = 0;
        1:       d = $urandom_range(0, p + 3);
        2:       d = p + 1 + $urandom_range(0, 2000);
        default: d = $urandom_range(0, p);
      endcase
      ph = ($urandom_range(0, 7) == 0) ? 5000 : $urandom_range(0, p + 5);
      en = ($urandom_range(0, 9) != 0);
      period = CW'(p);
      duty   = CW'(d);
      phase  = CW'(ph);
      load   = ($urandom_range(0, 2) == 0);
      n = $urandom_range(1, 40);
      for (int s = 0; s < int'(n); s++) begin
        step();
        load = 1'b0;
      end
      if ($urandom_range(0, 99) == 0) pulse_reset("rndrst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_shadow_dt.md
# pwm_shadow_dt

Shadow-registered, phase-shiftable PWM generator with complementary dead-time outputs. It sits directly downstream of the duty saturator and consumes its 26-bit clamped duty word. It turns that word into gate drive signals at the fast PWM clock domain. Duty, period and phase updates are glitch-free: new values take effect only at a period boundary.

## Interface
- CNT_W, 26, counter and compare width
- DT, 4, dead-time in clk cycles (0 = no dead time)
- clk  in  1  PWM clock (fast domain)
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  run enable; 0 holds counter at 0 and forces outputs low
- load  in  1  one-cycle strobe; captures period/duty/phase into pending registers
- period  in  CNT_W  terminal count; PWM period = period+1 cycles
- duty  in  CNT_W  high-time in cycles
- phase  in  CNT_W  counter offset in cycles
- pwm_h  out  1  high-side drive
- pwm_l  out  1  low-side drive, complement of pwm_h with dead time
- cyc_start  out  1  one-cycle pulse at the first cycle of each period
- pending  out  1  loaded values not yet active

## Operation
- Reset:
  - cnt = 0.
  - Active set = {period 998, duty 0, phase 0}.
  - pending = 0.
  - pwm_h = pwm_l = cyc_start = 0.
- Counter:
  - When en = 1, cnt increments each clk.
  - At cnt == period_a, cnt wraps to 0.
- Pending registers:
  - load = 1 copies the inputs into pending_* and sets pending.
  - A later load before the boundary overwrites the pending values (last wins).
- Boundary transfer:
  - In the wrap cycle (cnt == period_a with en = 1), pending_* move into the active set and pending clears.
  - If load and wrap occur in the same cycle, the newly loaded values go to pending_* and are transferred at the following wrap.
- Disabled (en = 0):
  - cnt is held at 0 and outputs are 0.
  - load transfers directly to the active set on the next edge, and pending stays 0.
- Phase:
  - Effective phase is ph = min(phase_a, period_a).
  - Shifted count sc = (cnt >= ph) ? cnt − ph : cnt + period_a + 1 − ph.
- Raw output:
  - raw = (sc < duty_a).
  - duty_a = 0 gives constant low.
  - duty_a > period_a gives constant high (100 %); this is not an error.
- Dead time:
  - On every raw transition, a dead-time counter restarts.
  - pwm_h = raw_q AND (dt_cnt ≥ DT).
  - pwm_l = NOT raw_q AND (dt_cnt ≥ DT) AND en.
  - pwm_h and pwm_l are never both 1.
  - A pulse shorter than DT yields no output pulse on either side.
- cyc_start: asserted for the cycle whose registered output corresponds to cnt == 0.

## Timing
- Output latency:
  - raw is registered once.
  - pwm_h and pwm_l lag cnt by 1 cycle plus DT on rising edges.
- New values affect the output starting at cnt = 0 of the period following the wrap transfer, i.e. with the same 1-cycle latency.
- cyc_start is aligned with the first output cycle of each period, so its period is period_a+1 cycles.
- en falling:
  - Next edge: cnt = 0, outputs 0.
  - The dead-time counter saturates so that re-enable does not add an extra dead time on the first edge.
- rst_n asserted mid-period: all state returns to reset values immediately (asynchronous). Pending data is lost.
- Reset deassertion is synchronised by the consumer's reset tree; this block only samples rst_n asynchronously.

## Structure
- Package pwm_pkg:
  - CNT_W.
  - Default period (998).
  - Default duty (0).
  - Type pwm_cfg_t = {period, duty, phase}, used for both the pending and active sets.
- Sub-module pwm_deadtime:
  - Inputs: raw, en.
  - Outputs: pwm_h, pwm_l.
  - Owns the transition detection and the DT counter, with width clog2(DT+1).
- Top contains the counter, shadow registers, phase arithmetic and comparator.

## Test plan
- Basic duty: reset, en = 1, load {998, 499, 0}, DT = 0.
  - After the first wrap, pwm_h is high 499 of every 999 cycles.
  - cyc_start period is 999.
- Mid-period update: at cnt = 300, load duty 200.
  - The current period keeps duty 499.
  - The next period shows 200 high cycles.
  - pending is 1 from the load until the wrap.
  - A second load at cnt = 400 with duty 100 results in 100, not 200.
- Boundaries:
  - duty 0 gives pwm_h always 0 and pwm_l always 1.
  - duty 999 or 5000 with period 998 gives pwm_h always 1 and no glitch at the wrap.
  - load coincident with wrap: the values apply one period later.
- Phase: period 998, duty 499, phase 250.
  - The pwm_h rising edge is 250 cycles after the cyc_start-aligned edge seen with phase 0.
  - phase 2000 behaves as phase 998.
- Dead time: DT = 4, duty 499.
  - pwm_h high 495 cycles, pwm_l high 496 cycles, 4-cycle gaps at each transition, never overlapping.
  - duty 3 produces no pwm_h pulse.
- Reset and enable:
  - rst_n low at cnt = 600: outputs 0 immediately.
  - After release, the active set is {998, 0, 0}.
  - en low: outputs 0 and cnt 0; a load while disabled applies at once on re-enable.
